// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit of the E stage.
// Owns HI/LO, runs mult/multu/div/divu over a fixed number of cycles,
// handles mfhi/mflo/mthi/mtlo, and reports busy to the hazard unit.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] out,
    output logic        busy,
    output logic        start
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        K_MULT  = 2'd0,
        K_MULTU = 2'd1,
        K_DIV   = 2'd2,
        K_DIVU  = 2'd3
    } kind_t;

    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      opa;
    logic [31:0]      opb;
    kind_t            kind;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        div_s;
    logic [63:0]        div_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_we;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
    // Returns {remainder, quotient}; a zero divisor yields zeros (never written).
    function automatic logic [63:0] sdiv(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax, ay, q, r;
        ax = x[31] ? (~x + 32'd1) : x;
        ay = y[31] ? (~y + 32'd1) : y;
        q  = (ay == 32'd0) ? 32'd0 : ax / ay;
        r  = (ay == 32'd0) ? 32'd0 : ax % ay;
        if (x[31] ^ y[31]) q = ~q + 32'd1;
        if (x[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

    // Unsigned divide; returns {remainder, quotient}, zeros on a zero divisor.
    function automatic logic [63:0] udiv(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 64'd0;
        return {x % y, x / y};
    endfunction

    assign busy  = (cnt != '0);
    assign start = (op >= OP_MULT) && (op <= OP_DIVU) && !busy;

    // Result of the latched operation, written into HI/LO on the final count.
    always_comb begin
        prod_s = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
        prod_u = {32'd0, opa} * {32'd0, opb};
        div_s  = sdiv(opa, opb);
        div_u  = udiv(opa, opb);
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b1;
        case (kind)
            K_MULT:  {res_hi, res_lo} = prod_s;
            K_MULTU: {res_hi, res_lo} = prod_u;
            K_DIV:   {res_hi, res_lo} = div_s;
            default: {res_hi, res_lo} = div_u;
        endcase
        if ((kind == K_DIV || kind == K_DIVU) && opb == 32'd0) res_we = 1'b0;
    end

    // Zero-latency read port feeding the ALU a-input mux.
    always_comb begin
        case (op)
            OP_MFHI: out = hi;
            OP_MFLO: out = lo;
            default: out = 32'd0;
        endcase
    end

    // Counter, operand latch and HI/LO update; mt*/new starts only when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            cnt  <= '0;
            opa  <= 32'd0;
            opb  <= 32'd0;
            kind <= K_MULT;
        end else if (busy) begin
            if (cnt == CNT_W'(1)) begin
                cnt <= '0;
                if (res_we) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (start) begin
            opa <= a;
            opb <= b;
            case (op)
                OP_MULT:  begin kind <= K_MULT;  cnt <= CNT_W'(MULT_CYCLES); end
                OP_MULTU: begin kind <= K_MULTU; cnt <= CNT_W'(MULT_CYCLES); end
                OP_DIV:   begin kind <= K_DIV;   cnt <= CNT_W'(DIV_CYCLES);  end
                default:  begin kind <= K_DIVU;  cnt <= CNT_W'(DIV_CYCLES);  end
            endcase
        end else if (op == OP_MTHI) begin
            hi <= a;
        end else if (op == OP_MTLO) begin
            lo <= a;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected values,
// a negedge monitor pops and compares them against out/busy/start.
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam int SEL_OUT   = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_START = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [3:0]  op = 4'd0;
    logic [31:0] out;
    logic        busy;
    logic        start;

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t       sbq[$];
    item_t       it;
    logic [31:0] act;
    bit          sample = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op),
        .out(out), .busy(busy), .start(start)
    );

    always #5 clk = ~clk;

    // Monitor: on the falling edge, drain everything queued for this cycle.
    always @(negedge clk) begin
        if (sample) begin
            while (sbq.size() > 0) begin
                it = sbq.pop_front();
                case (it.sel)
                    SEL_OUT:  act = out;
                    SEL_BUSY: act = {31'd0, busy};
                    default:  act = {31'd0, start};
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", it.nm, act, it.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic chk(input string nm, input int sel, input logic [31:0] exp);
        item_t e;
        e.nm  = nm;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
        sample = 1'b1;
    endtask

    // Issue a mult/div op, check start, busy for exactly n cycles, then idle.
    task automatic run(input string nm, input logic [3:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input int n);
        op = o; a = aa; b = bb;
        chk({nm, " start"}, SEL_START, 32'd1);
        tick();
        op = 4'd0; a = $urandom; b = $urandom;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s busy%0d", nm, i), SEL_BUSY, 32'd1);
            tick();
        end
        chk({nm, " done"}, SEL_BUSY, 32'd0);
    endtask

    // Read HI then LO through out.
    task automatic rd(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
        op = 4'd5;
        chk({nm, " hi"}, SEL_OUT, ehi);
        tick();
        op = 4'd6;
        chk({nm, " lo"}, SEL_OUT, elo);
        tick();
        op = 4'd0;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        rd("post_reset", 32'd0, 32'd0);
        op = 4'd7; a = 32'h55;
        tick();
        op = 4'd0;
        rd("mthi55", 32'h55, 32'd0);
        reset = 1'b0; op = 4'd5;
        chk("async_rst busy", SEL_BUSY, 32'd0);
        chk("async_rst hi", SEL_OUT, 32'd0);
        tick();
        op = 4'd6;
        chk("async_rst lo", SEL_OUT, 32'd0);
        tick();
        reset = 1'b1; op = 4'd0;
        tick();

        // Multiply
        run("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, MC);
        rd("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, MC);
        rd("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        // Divide
        run("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC);
        rd("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_pos", 4'd3, 32'd7, 32'hFFFF_FFFE, DC);
        rd("div_pos", 32'd1, 32'hFFFF_FFFD);
        run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
        rd("div_ovf", 32'd0, 32'h8000_0000);

        // Divide by zero leaves HI/LO alone
        op = 4'd7; a = 32'h11; tick();
        op = 4'd8; a = 32'h22; tick();
        run("divu0", 4'd4, 32'd7, 32'd0, DC);
        rd("divu0", 32'h11, 32'h22);

        // Ops presented while busy are ignored
        op = 4'd1; a = 32'd3; b = 32'd4;
        tick();
        op = 4'd0;
        chk("ign busy0", SEL_BUSY, 32'd1);
        tick();
        op = 4'd7; a = 32'hDEAD;
        chk("ign busy1", SEL_BUSY, 32'd1);
        tick();
        op = 4'd3; a = 32'd9; b = 32'd2;
        chk("ign start_low", SEL_START, 32'd0);
        chk("ign busy2", SEL_BUSY, 32'd1);
        tick();
        op = 4'd0;
        chk("ign busy3", SEL_BUSY, 32'd1);
        tick();
        chk("ign busy4", SEL_BUSY, 32'd1);
        tick();
        chk("ign not_extended", SEL_BUSY, 32'd0);
        rd("ign", 32'd0, 32'd12);

        // mthi/mtlo and start decode
        op = 4'd7; a = 32'h1234_5678; tick();
        op = 4'd8; a = 32'h9ABC_DEF0; tick();
        rd("mt", 32'h1234_5678, 32'h9ABC_DEF0);
        op = 4'd9;
        chk("op9 start", SEL_START, 32'd0);
        chk("op9 out", SEL_OUT, 32'd0);
        tick();

        // Reset mid-operation
        op = 4'd3; a = 32'd100; b = 32'd7;
        tick();
        op = 4'd0;
        tick(); tick(); tick();
        chk("rst_mid pre", SEL_BUSY, 32'd1);
        tick();
        reset = 1'b0; op = 4'd5;
        chk("rst_mid busy", SEL_BUSY, 32'd0);
        chk("rst_mid hi", SEL_OUT, 32'd0);
        tick();
        reset = 1'b1; op = 4'd0;
        repeat (DC + 2) tick();
        chk("rst_mid idle", SEL_BUSY, 32'd0);
        rd("rst_mid", 32'd0, 32'd0);

        tick();
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
